// File: rtl/dsc_pkg.sv
// Shared definitions for the deterministic stochastic-number generator pair.
package dsc_pkg;

  localparam int SNG_WIDTH_DEFAULT = 4;
  localparam int STREAM_LEN        = 1 << SNG_WIDTH_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } dsc_state_t;

endpackage

// File: rtl/dsc_sng_pair_sng_unit.sv
// One stream source: operand latch, wrapping counter and (count < operand) compare.
module sng_unit #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] val,
  output logic         stream_bit,
  output logic         wrap
);

  logic [W-1:0] cnt;
  logic [W-1:0] lat;
  logic [W-1:0] base;
  logic [W-1:0] ref_v;

  // On load the compare sees the fresh operand and a zero count, so the
  // first stream bit is issued on the same edge that accepts the operand.
  assign base       = load ? '0 : cnt;
  assign ref_v      = load ? val : lat;
  assign stream_bit = (base < ref_v);
  assign wrap       = en & (base == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      lat <= '0;
    end else begin
      if (load)
        lat <= val;
      if (load || en)
        cnt <= base + {{(W-1){1'b0}}, en};
    end
  end

endmodule

// File: rtl/dsc_sng_pair.sv
// Stochastic-number generator pair with AND-product accumulator.
module dsc_sng_pair
  import dsc_pkg::*;
#(
  parameter int SNG_WIDTH = SNG_WIDTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [SNG_WIDTH-1:0]   a_in,
  input  logic [SNG_WIDTH-1:0]   b_in,
  output logic                   ready,
  output logic                   bit_valid,
  output logic                   a_bit,
  output logic                   b_bit,
  output logic                   done,
  output logic [2*SNG_WIDTH-1:0] product
);

  // state | meaning
  // IDLE  | waiting for start, product held
  // RUN   | streaming bits; one extra cycle after the final bit to fold it in
  // FIN   | done pulse, product valid, start accepted for back-to-back runs

  dsc_state_t state, state_nx;

  logic                   accept;
  logic                   a_stream, b_stream;
  logic                   wrap_a, wrap_b;
  logic                   last_q;
  logic [2*SNG_WIDTH-1:0] acc;
  logic [2*SNG_WIDTH-1:0] acc_nx;

  sng_unit #(.W(SNG_WIDTH)) u_sng_a (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .en         (1'b1),
    .val        (a_in),
    .stream_bit (a_stream),
    .wrap       (wrap_a)
  );

  sng_unit #(.W(SNG_WIDTH)) u_sng_b (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .en         (wrap_a),
    .val        (b_in),
    .stream_bit (b_stream),
    .wrap       (wrap_b)
  );

  assign accept = start & (state != RUN);
  assign ready  = (state != RUN);
  assign done   = (state == FIN);
  assign acc_nx = acc + {{(2*SNG_WIDTH-1){1'b0}}, a_bit & b_bit};

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = RUN;
      RUN:     if (last_q) state_nx = FIN;
      FIN:     state_nx = accept ? RUN : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_valid <= 1'b0;
      a_bit     <= 1'b0;
      b_bit     <= 1'b0;
      last_q    <= 1'b0;
      acc       <= '0;
      product   <= '0;
    end else if (accept) begin
      bit_valid <= 1'b1;
      a_bit     <= a_stream;
      b_bit     <= b_stream;
      last_q    <= 1'b0;
      acc       <= '0;
      product   <= '0;
    end else if (state == RUN) begin
      if (last_q) begin
        bit_valid <= 1'b0;
        a_bit     <= 1'b0;
        b_bit     <= 1'b0;
        last_q    <= 1'b0;
        product   <= acc_nx;
      end else begin
        bit_valid <= 1'b1;
        a_bit     <= a_stream;
        b_bit     <= b_stream;
        last_q    <= wrap_b;
        acc       <= acc_nx;
      end
    end
  end

endmodule

// File: tb/tb_dsc_sng_pair.sv
// Randomized self-checking bench for dsc_sng_pair against an index-based stream model.
module tb_dsc_sng_pair;
  import dsc_pkg::*;

  localparam int W   = SNG_WIDTH_DEFAULT;
  localparam int RUN_LEN = STREAM_LEN * STREAM_LEN;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [W-1:0]   a_in = '0;
  logic [W-1:0]   b_in = '0;
  logic           ready, bit_valid, a_bit, b_bit, done;
  logic [2*W-1:0] product;

  int n_cmp = 0;
  int n_err = 0;

  dsc_sng_pair #(.SNG_WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .a_in      (a_in),
    .b_in      (b_in),
    .ready     (ready),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .done      (done),
    .product   (product)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a run is the bit index i = 0..RUN_LEN-1; bit i pairs
  // a-index i%16 with b-index i/16. The result follows the last bit.
  bit m_valid = 1'b0;
  bit m_done  = 1'b0;
  int m_i = 0, m_a = 0, m_b = 0, m_prod = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_valid = 1'b0; m_done = 1'b0; m_i = 0; m_prod = 0;
    end else if (start && !m_valid) begin
      m_valid = 1'b1; m_done = 1'b0; m_i = 0; m_prod = 0;
      m_a = int'(a_in); m_b = int'(b_in);
    end else if (m_valid) begin
      if (m_i == RUN_LEN - 1) begin
        m_valid = 1'b0; m_done = 1'b1; m_prod = m_a * m_b;
      end else begin
        m_i++;
      end
    end else begin
      m_done = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("ready",     ready,     !m_valid);
    chk("bit_valid", bit_valid, m_valid);
    chk("a_bit",     a_bit,     m_valid && ((m_i % STREAM_LEN) < m_a));
    chk("b_bit",     b_bit,     m_valid && ((m_i / STREAM_LEN) < m_b));
    chk("done",      done,      m_done);
    chk("product",   product,   m_prod);
  end

  task automatic wait_done(input bit release_start, input bit toggle,
                           output int nvalid, output logic [7:0] prod, output bit got,
                           output logic [255:0] sa, output logic [255:0] sb);
    nvalid = 0; prod = '0; got = 1'b0; sa = '0; sb = '0;
    for (int c = 0; c < 400 && !got; c++) begin
      @(negedge clk);
      if (release_start) start = 1'b0;
      if (toggle) begin
        a_in = W'($urandom);
        b_in = W'($urandom);
      end
      if (bit_valid) begin
        if (nvalid < 256) begin
          sa[nvalid] = a_bit;
          sb[nvalid] = b_bit;
        end
        nvalid++;
      end
      if (done) begin
        got = 1'b1;
        prod = product;
      end
    end
    chk("done_seen", got, 1'b1);
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input bit toggle,
                        input int exp_prod, input string name);
    int nv;
    logic [7:0] p;
    bit g;
    logic [255:0] sa, sb;
    @(negedge clk);
    start = 1'b1; a_in = a; b_in = b;
    wait_done(1'b1, toggle, nv, p, g, sa, sb);
    chk({name, "_nvalid"}, nv, 256);
    chk({name, "_product"}, p, exp_prod);
  endtask

  initial begin
    int nv;
    logic [7:0] p;
    bit g, saw_done;
    logic [255:0] sa, sb, ea, eb;

    #1 rst = 1'b1;
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_valid", bit_valid, 1'b0);
    chk("rst_product", product, 0);
    chk("rst_done", done, 1'b0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // (3,5): pinned stream shapes
    start = 1'b1; a_in = 4'd3; b_in = 4'd5;
    wait_done(1'b1, 1'b0, nv, p, g, sa, sb);
    for (int k = 0; k < 256; k++) begin
      ea[k] = ((k % 16) < 3);
      eb[k] = (k < 80);
    end
    chk("t35_nvalid", nv, 256);
    chk("t35_a_stream", sa, ea);
    chk("t35_b_stream", sb, eb);
    chk("t35_product", p, 15);

    run_op(4'd15, 4'd15, 1'b0, 225, "t1515");
    @(negedge clk);
    start = 1'b1; a_in = 4'd0; b_in = 4'd9;
    wait_done(1'b1, 1'b0, nv, p, g, sa, sb);
    chk("t09_a_never", sa, 256'd0);
    chk("t09_product", p, 0);
    run_op(4'd15, 4'd0, 1'b0, 0, "t150");

    // start held high: no reload in RUN, back-to-back with one gap cycle
    @(negedge clk);
    start = 1'b1; a_in = 4'd7; b_in = 4'd6;
    wait_done(1'b0, 1'b0, nv, p, g, sa, sb);
    chk("hold_nvalid", nv, 256);
    chk("hold_product1", p, 42);
    @(negedge clk);
    chk("hold_gap_one", bit_valid, 1'b1);
    start = 1'b0;
    wait_done(1'b1, 1'b0, nv, p, g, sa, sb);
    chk("hold_product2", p, 42);

    run_op(4'd9, 4'd4, 1'b1, 36, "toggle94");

    // reset mid-run
    @(negedge clk);
    start = 1'b1; a_in = 4'd12; b_in = 4'd10;
    repeat (100) begin
      @(negedge clk);
      start = 1'b0;
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready, 1'b1);
    chk("mid_rst_valid", bit_valid, 1'b0);
    chk("mid_rst_abit", a_bit, 1'b0);
    chk("mid_rst_product", product, 0);
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("mid_rst_no_done", saw_done, 1'b0);
    run_op(4'd12, 4'd10, 1'b0, 120, "after_rst");

    for (int r = 0; r < 4; r++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 15));
      rb = W'($urandom_range(0, 15));
      run_op(ra, rb, 1'b1, int'(ra) * int'(rb), "random");
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
